// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single physical-register writeback port among NUM_REQ result
// sources (ALU, BJU, MULDIV, LSU). Each cycle a round-robin scan starting at
// rr_ptr picks at most one valid source. Its result is captured in a
// one-entry output register that feeds the writeback stage. A saturating
// counter records the cycles in which two or more sources compete.
//
// Ports:
//   clock           clock
//   reset_n         asynchronous active-low reset
//   redirect_flush  kills the buffered entry and blocks accepts this cycle
//   req_valid       per-source result valid
//   req_ready       per-source accept (at most one bit set)
//   req_prd         flattened destination pregs, source i at [i*PREG_W +: PREG_W]
//   req_data        flattened result data, source i at [i*DATA_W +: DATA_W]
//   wb_valid        buffered entry valid
//   wb_ready        writeback stage consumes the buffered entry
//   wb_prd          buffered destination preg
//   wb_data         buffered result data
//   wb_src          index of the source that produced the buffered entry
//   contention_cnt  saturating count of cycles with >= 2 requesters
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the request side req_ready[i] is offered only to the granted
// source, so req_valid[i] & req_ready[i] is the accept. On the writeback side
// wb_valid & wb_ready consumes the entry unless redirect_flush is high in
// the same cycle, in which case the entry is killed instead.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = 6,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      redirect_flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*PREG_W-1:0] req_prd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [PREG_W-1:0]         wb_prd,
    output logic [DATA_W-1:0]         wb_data,
    output logic [SRC_W-1:0]          wb_src,
    output logic [CNT_W-1:0]          contention_cnt
);

    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   next_ptr;
    logic               slot_free;
    logic               accept;
    logic               contention;

    // Round-robin scan: rr_ptr first, then upward with wrap. The first valid
    // source found wins; everything after it is ignored.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    // The slot can take a new entry when empty or when the current one
    // leaves this cycle; this is what gives back-to-back throughput.
    assign slot_free = ~wb_valid | wb_ready;
    assign req_ready = grant & {NUM_REQ{slot_free & ~redirect_flush}};
    assign accept    = |req_ready;

    assign next_ptr  = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

    // Two or more bits set exactly when clearing the lowest set bit
    // leaves something behind.
    assign contention = |(req_valid & (req_valid - NUM_REQ'(1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid       <= 1'b0;
            wb_prd         <= '0;
            wb_data        <= '0;
            wb_src         <= '0;
            rr_ptr         <= '0;
            contention_cnt <= '0;
        end else begin
            if (contention && (contention_cnt != {CNT_W{1'b1}})) begin
                contention_cnt <= contention_cnt + CNT_W'(1);
            end

            if (redirect_flush) begin
                // Entry is killed; pointer and data fields stay put.
                wb_valid <= 1'b0;
            end else if (accept) begin
                wb_valid <= 1'b1;
                wb_prd   <= req_prd[grant_idx*PREG_W +: PREG_W];
                wb_data  <= req_data[grant_idx*DATA_W +: DATA_W];
                wb_src   <= grant_idx;
                rr_ptr   <= next_ptr;
            end else if (wb_ready) begin
                // Drain with no replacement; data fields are left stale.
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int PREG_W  = 6;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 4;
  localparam int SRC_W   = 2;
  localparam int ITEM_W  = SRC_W + PREG_W + DATA_W;

  logic                      clock;
  logic                      reset_n;
  logic                      redirect_flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*PREG_W-1:0] req_prd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [PREG_W-1:0]         wb_prd;
  logic [DATA_W-1:0]         wb_data;
  logic [SRC_W-1:0]          wb_src;
  logic [CNT_W-1:0]          contention_cnt;

  int checks = 0;
  int errors = 0;

  logic [ITEM_W-1:0] exp_q[$];

  wb_port_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PREG_W (PREG_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .redirect_flush(redirect_flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_prd       (req_prd),
    .req_data      (req_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_prd        (wb_prd),
    .wb_data       (wb_data),
    .wb_src        (wb_src),
    .contention_cnt(contention_cnt)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d);
    req_prd[i*PREG_W +: PREG_W] = p;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_exp(input int s, input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d);
    exp_q.push_back({SRC_W'(s), p, d});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every consumed writeback must match the queue head
  always @(negedge clock) begin
    logic [ITEM_W-1:0] item;
    if (reset_n && wb_valid && wb_ready && !redirect_flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected actual src=%0d prd=%0d data=%0h expected=none",
                 wb_src, wb_prd, wb_data);
      end else begin
        item = exp_q.pop_front();
        if ({wb_src, wb_prd, wb_data} !== item) begin
          errors++;
          $display("FAIL wb_entry actual src=%0d prd=%0d data=%0h expected src=%0d prd=%0d data=%0h",
                   wb_src, wb_prd, wb_data,
                   item[ITEM_W-1 -: SRC_W], item[DATA_W +: PREG_W], item[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    redirect_flush = 1'b0;
    req_valid      = '0;
    req_prd        = '0;
    req_data       = '0;
    wb_ready       = 1'b0;

    // reset state
    repeat (2) cyc();
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_wb_prd", 64'(wb_prd), 64'd0);
    chk("reset_wb_data", wb_data, 64'd0);
    chk("reset_wb_src", 64'(wb_src), 64'd0);
    chk("reset_cnt", 64'(contention_cnt), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    cyc();

    // single request from source 0 (rr 0 -> 1)
    set_src(0, 6'd5, 64'hAA);
    req_valid = 4'b0001;
    wb_ready  = 1'b1;
    settle();
    chk("t1_req_ready", 64'(req_ready), 64'b0001);
    push_exp(0, 6'd5, 64'hAA);
    cyc();
    req_valid = 4'b0000;
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    cyc();
    chk("t1_drain", 64'(wb_valid), 64'd0);

    // source 3 alone (rr 1 -> 0)
    set_src(3, 6'd33, 64'h3333);
    req_valid = 4'b1000;
    settle();
    chk("t1b_req_ready", 64'(req_ready), 64'b1000);
    push_exp(3, 6'd33, 64'h3333);
    cyc();
    req_valid = 4'b0000;
    cyc();

    // all four compete for 4 cycles: grants 0,1,2,3
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 6'(10 + i), 64'h1000 + 64'(i));
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      settle();
      chk($sformatf("t2_req_ready_%0d", i), 64'(req_ready), 64'(4'b0001 << i));
      push_exp(i, 6'(10 + i), 64'h1000 + 64'(i));
      cyc();
    end
    req_valid = 4'b0000;
    chk("t2_cnt", 64'(contention_cnt), 64'd4);
    cyc();
    cyc();

    // hold under backpressure (rr 0 -> 1 after load)
    set_src(0, 6'd20, 64'hBEEF);
    req_valid = 4'b0001;
    push_exp(0, 6'd20, 64'hBEEF);
    cyc();
    wb_ready  = 1'b0;
    set_src(2, 6'd22, 64'hC0DE);
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t3_hold_ready_%0d", i), 64'(req_ready), 64'd0);
      chk($sformatf("t3_hold_valid_%0d", i), 64'(wb_valid), 64'd1);
      chk($sformatf("t3_hold_data_%0d", i), wb_data, 64'hBEEF);
      cyc();
    end
    wb_ready = 1'b1;
    settle();
    chk("t3_release_ready", 64'(req_ready), 64'b0100);
    push_exp(2, 6'd22, 64'hC0DE);
    cyc();
    req_valid = 4'b0000;
    chk("t3_src", 64'(wb_src), 64'd2);
    cyc();
    cyc();

    // flush (rr 3; source 0 loaded -> rr 1, entry killed)
    wb_ready  = 1'b0;
    set_src(0, 6'd40, 64'hDEAD);
    req_valid = 4'b0001;
    cyc();
    chk("t4_loaded", 64'(wb_valid), 64'd1);
    redirect_flush = 1'b1;
    wb_ready       = 1'b1;
    set_src(1, 6'd41, 64'hF1F1);
    req_valid      = 4'b0010;
    settle();
    chk("t4_flush_ready", 64'(req_ready), 64'd0);
    cyc();
    redirect_flush = 1'b0;
    chk("t4_flushed_valid", 64'(wb_valid), 64'd0);
    req_valid = 4'b0011;
    settle();
    chk("t4_after_ready", 64'(req_ready), 64'b0010);
    push_exp(1, 6'd41, 64'hF1F1);
    cyc();
    req_valid = 4'b0000;
    cyc();
    cyc();

    // wrap: rr 2 -> 3 via source 2, then 1001 grants 3 then 0
    set_src(2, 6'd50, 64'h5050);
    set_src(3, 6'd53, 64'h5353);
    set_src(0, 6'd54, 64'h5454);
    req_valid = 4'b0100;
    push_exp(2, 6'd50, 64'h5050);
    cyc();
    req_valid = 4'b1001;
    settle();
    chk("t5_wrap_ready3", 64'(req_ready), 64'b1000);
    push_exp(3, 6'd53, 64'h5353);
    cyc();
    settle();
    chk("t5_wrap_ready0", 64'(req_ready), 64'b0001);
    push_exp(0, 6'd54, 64'h5454);
    cyc();
    req_valid = 4'b0000;
    chk("t5_cnt", 64'(contention_cnt), 64'd7);
    cyc();
    cyc();

    // saturation: counter at 7, 20 contention cycles, entry held then reset
    wb_ready  = 1'b0;
    req_valid = 4'b0011;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 7) chk("t6_cnt_14", 64'(contention_cnt), 64'd14);
      if (i == 8) chk("t6_cnt_15", 64'(contention_cnt), 64'd15);
    end
    chk("t6_cnt_sat", 64'(contention_cnt), 64'd15);
    chk("t6_held_valid", 64'(wb_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(wb_valid), 64'd0);
    chk("t6_async_cnt", 64'(contention_cnt), 64'd0);
    chk("t6_async_data", wb_data, 64'd0);
    req_valid = 4'b0000;
    cyc();
    reset_n = 1'b1;
    cyc();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
